mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage controller between the execute stage and the byte-addressed, big-endian `Data_Memory`, which has 1024 bytes and registered 16-bit reads. It accepts one load or store request at a time through a valid/ready handshake and checks alignment and range. It sequences the memory's MemRead and MemWrite strobes, performs read-modify-write for byte stores, and returns formatted load data with a destination tag to write-back.

## Interface
Parameters:
- MEM_BYTES, 1024: data memory size in bytes; addresses at or above this are out of range.
- TAG_W, 3: width of the destination-register tag.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  execute stage presents a request.
- req_ready  out  1  unit accepts a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access, 0 = 16-bit word access.
- req_signed  in  1  byte load: 1 = sign-extend, 0 = zero-extend.
- req_address  in  16  byte address.
- req_store_data  in  16  store data; a byte store uses bits [7:0].
- req_tag  in  TAG_W  destination register of a load.
- address  out  16  to Data_Memory.
- write_data  out  16  to Data_Memory.
- MemRead  out  1  to Data_Memory.
- MemWrite  out  1  to Data_Memory.
- read_data_mem  in  16  from Data_Memory; valid the cycle after MemRead was high.
- wb_valid  out  1  one-cycle pulse: load result is valid.
- wb_data  out  16  load result.
- wb_tag  out  TAG_W  tag of the load result.
- err_valid  out  1  one-cycle pulse: request rejected.
- err_code  out  2  01 = misaligned word, 10 = out of range.

## Operation
- FSM states: IDLE, READ, LOAD_FMT, RMW_WRITE, STORE, ERR.
- req_ready = 1 only in IDLE. A request is accepted when req_valid and req_ready are both high at a rising edge. On accept, all request fields are registered.
- Checks at accept, in priority order:
  - Out of range: address ≥ MEM_BYTES, or a word access with address = MEM_BYTES-1. Go to ERR with code 10.
  - Misaligned word: a word access with address[0] = 1. Go to ERR with code 01.
- Aligned address A = {addr[15:1], 1'b0}. Byte at A is bits [15:8]; byte at A+1 is bits [7:0].
- Word store: IDLE → STORE. STORE drives MemWrite = 1, address = addr, write_data = store_data, then returns to IDLE.
- Load (word or byte): IDLE → READ. READ drives MemRead = 1, address = A, then goes to LOAD_FMT.
- LOAD_FMT formats read_data_mem, registers the result into wb_data and wb_tag, pulses wb_valid, then returns to IDLE.
  - Word: result = read_data_mem.
  - Byte: the selected byte is [15:8] if addr[0] = 0, else [7:0]. It is sign- or zero-extended to 16 bits according to req_signed.
- Byte store: IDLE → READ (MemRead) → RMW_WRITE.
  - RMW_WRITE drives MemWrite = 1, address = A, write_data = read_data_mem with the selected byte replaced by store_data[7:0]. Then it returns to IDLE.
- ERR: pulses err_valid and err_code for one cycle, then returns to IDLE. No memory strobe is issued.
- MemRead and MemWrite are never high in the same cycle, and each is high for exactly one cycle per access.
- address and write_data are 0 whenever neither strobe is high.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE; req_ready = 1.
  - MemRead = MemWrite = 0; address = write_data = 0.
  - wb_valid = 0, wb_data = 0, wb_tag = 0; err_valid = 0, err_code = 0.
- Reset during any state aborts the operation. A byte store aborted in READ never writes; the memory is untouched.
- Cycle numbering: accept at edge E0; "cycle k" is the cycle after edge Ek.
- Word store: MemWrite high in cycle 0, memory updated at E1, req_ready high in cycle 1. Throughput is one word store per 2 cycles.
- Load: MemRead high in cycle 0, data captured by memory at E1, result registered at E2. wb_valid is high in cycle 2 and req_ready is high in cycle 2.
- Byte store: MemRead high in cycle 0, MemWrite high in cycle 1, memory updated at E2, req_ready high in cycle 2.
- Error: err_valid is high in cycle 0 and req_ready is high in cycle 1.
- wb_data and wb_tag hold their values between pulses. err_code holds its value between pulses.
- A request held valid while req_ready is low is not consumed. The requester keeps its fields stable until acceptance.

## Test plan
- Word store then load: store 0xBEEF to address 0x0010, then load from 0x0010 → memory bytes 0x10 = 0xBE and 0x11 = 0xEF; wb_valid in cycle 2 with wb_data = 0xBEEF and the correct wb_tag.
- Byte loads, with memory word 0x0020 = 0x80F7:
  - load byte signed at 0x0020 → 0xFF80.
  - load byte unsigned at 0x0021 → 0x00F7.
  - load byte signed at 0x0021 → 0xFFF7.
- Byte store read-modify-write:
  - word 0x0030 = 0x1234; byte store 0xAB to 0x0031 → word reads back 0x12AB.
  - byte store 0xCD to 0x0030 → word reads back 0xCDAB.
  - MemRead and MemWrite are each one cycle long, in consecutive cycles.
- Errors:
  - word load at 0x0005 → err_valid with err_code = 01; no strobe issued.
  - word store at 0x03FF → err_code = 10.
  - byte load at 0x0400 → err_code = 10.
  - byte load at 0x03FF → succeeds.
- Back-to-back handshake: req_valid held high with 3 queued requests → each is accepted only when req_ready = 1; no request is lost or duplicated; strobe counts match the request count.
- Reset mid byte store: assert rst_n = 0 while in READ → all outputs go to their reset values immediately; the target word is unchanged; the next request executes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Memory-stage controller between execute and a byte-addressed, big-endian
// data memory with registered 16-bit reads. It takes one load/store at a time,
// checks range and alignment, sequences MemRead/MemWrite, does read-modify-write
// for byte stores and returns formatted load data with a tag to write-back.
//
// Request handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only while the unit is idle. The
// requester holds every req_* field stable until that edge.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_*                 request from execute (valid/ready handshake)
//   address, write_data,
//   MemRead, MemWrite     to the data memory (address/write_data are 0 when idle)
//   read_data_mem         from the data memory, valid the cycle after MemRead
//   wb_valid/wb_data/wb_tag   load result to write-back (valid is a 1-cycle pulse)
//   err_valid/err_code    rejected request (01 misaligned word, 10 out of range)
//   dbg_state             current FSM state
module mem_access_unit #(
  parameter int MEM_BYTES = 1024,
  parameter int TAG_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic             req_byte,
  input  logic             req_signed,
  input  logic [15:0]      req_address,
  input  logic [15:0]      req_store_data,
  input  logic [TAG_W-1:0] req_tag,
  output logic [15:0]      address,
  output logic [15:0]      write_data,
  output logic             MemRead,
  output logic             MemWrite,
  input  logic [15:0]      read_data_mem,
  output logic             wb_valid,
  output logic [15:0]      wb_data,
  output logic [TAG_W-1:0] wb_tag,
  output logic             err_valid,
  output logic [1:0]       err_code,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    LOAD_FMT  = 3'd2,
    RMW_WRITE = 3'd3,
    STORE     = 3'd4,
    ERR       = 3'd5
  } state_t;

  // One extra bit so a MEM_BYTES of 65536 still compares correctly.
  localparam logic [16:0] LIMIT = 17'(MEM_BYTES);

  state_t state, state_next;

  logic             r_write;
  logic             r_byte;
  logic             r_signed;
  logic [15:0]      r_addr;
  logic [15:0]      r_data;
  logic [TAG_W-1:0] r_tag;

  logic        accept;
  logic        out_of_range;
  logic        misaligned;
  logic [15:0] aligned_addr;
  logic [7:0]  sel_byte;
  logic [15:0] load_result;
  logic [15:0] merged_word;

  assign accept = req_valid && req_ready;

  // A word at the last byte address would spill past the end of memory.
  assign out_of_range = ({1'b0, req_address} >= LIMIT) ||
                        (!req_byte && ({1'b0, req_address} == (LIMIT - 17'd1)));
  assign misaligned   = !req_byte && req_address[0];

  assign aligned_addr = {r_addr[15:1], 1'b0};

  // Big-endian: even byte lives in [15:8], odd byte in [7:0].
  assign sel_byte    = r_addr[0] ? read_data_mem[7:0] : read_data_mem[15:8];
  assign load_result = r_byte ? {{8{r_signed & sel_byte[7]}}, sel_byte} : read_data_mem;
  assign merged_word = r_addr[0] ? {read_data_mem[15:8], r_data[7:0]}
                                 : {r_data[7:0], read_data_mem[7:0]};

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write  <= 1'b0;
      r_byte   <= 1'b0;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_tag    <= '0;
      err_code <= 2'b00;
    end else if (accept) begin
      r_write  <= req_write;
      r_byte   <= req_byte;
      r_signed <= req_signed;
      r_addr   <= req_address;
      r_data   <= req_store_data;
      r_tag    <= req_tag;
      if (out_of_range) begin
        err_code <= 2'b10;
      end else if (misaligned) begin
        err_code <= 2'b01;
      end
    end
  end

  // Load result is registered so wb_data/wb_tag hold between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_tag   <= '0;
    end else begin
      wb_valid <= (state == LOAD_FMT);
      if (state == LOAD_FMT) begin
        wb_data <= load_result;
        wb_tag  <= r_tag;
      end
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    address    = '0;
    write_data = '0;
    err_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (out_of_range || misaligned) begin
            state_next = ERR;
          end else if (req_write && !req_byte) begin
            state_next = STORE;
          end else begin
            // Loads and byte stores both start with a read.
            state_next = READ;
          end
        end
      end
      READ: begin
        MemRead    = 1'b1;
        address    = aligned_addr;
        state_next = r_write ? RMW_WRITE : LOAD_FMT;
      end
      LOAD_FMT: begin
        state_next = IDLE;
      end
      RMW_WRITE: begin
        MemWrite   = 1'b1;
        address    = aligned_addr;
        write_data = merged_word;
        state_next = IDLE;
      end
      STORE: begin
        MemWrite   = 1'b1;
        address    = r_addr;
        write_data = r_data;
        state_next = IDLE;
      end
      ERR: begin
        err_valid  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: behavioural big-endian data memory, table of
// request vectors with per-cycle expectations, load-result scoreboard, and
// hand-written back-to-back and reset-abort sequences.
module tb_mem_access_unit;

  localparam int TAG_W = 3;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic             req_byte;
  logic             req_signed;
  logic [15:0]      req_address;
  logic [15:0]      req_store_data;
  logic [TAG_W-1:0] req_tag;
  logic [15:0]      address;
  logic [15:0]      write_data;
  logic             MemRead;
  logic             MemWrite;
  logic [15:0]      read_data_mem;
  logic             wb_valid;
  logic [15:0]      wb_data;
  logic [TAG_W-1:0] wb_tag;
  logic             err_valid;
  logic [1:0]       err_code;
  logic [2:0]       dbg_state;

  int checks;
  int failures;
  int rd_strobes;
  int wr_strobes;
  int accepts;

  logic [TAG_W+15:0] exp_q[$];

  logic [7:0] mem [0:1023];

  mem_access_unit #(.MEM_BYTES(1024), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte(req_byte), .req_signed(req_signed), .req_address(req_address),
    .req_store_data(req_store_data), .req_tag(req_tag),
    .address(address), .write_data(write_data), .MemRead(MemRead),
    .MemWrite(MemWrite), .read_data_mem(read_data_mem),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_tag(wb_tag),
    .err_valid(err_valid), .err_code(err_code), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- data memory model ----------------
  always @(posedge clk) begin
    if (MemRead) begin
      read_data_mem <= {mem[address[9:0]], mem[address[9:0] + 10'd1]};
    end
    if (MemWrite) begin
      mem[address[9:0]]         <= write_data[15:8];
      mem[address[9:0] + 10'd1] <= write_data[7:0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (MemRead)  rd_strobes++;
      if (MemWrite) wr_strobes++;
      if (req_valid && req_ready) accepts++;
      if (MemRead && MemWrite) chk("strobe_overlap", 1, 0);
      if (!MemRead && !MemWrite && (address != 16'h0 || write_data != 16'h0))
        chk("idle_bus_zero", {address, write_data}, 0);
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wb", 1, 0);
        end else begin
          logic [TAG_W+15:0] e;
          e = exp_q.pop_front();
          chk("wb_result", {wb_tag, wb_data}, e);
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic             wr;
    logic             by;
    logic             sg;
    logic [15:0]      addr;
    logic [15:0]      data;
    logic [TAG_W-1:0] tag;
    logic [1:0]       exp_err;
    logic [15:0]      exp;     // load result, or value written to memory
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic wr, logic by, logic sg, logic [15:0] a,
                              logic [15:0] d, logic [TAG_W-1:0] t,
                              logic [1:0] ee, logic [15:0] ex);
    vec_t v;
    v.wr = wr; v.by = by; v.sg = sg; v.addr = a; v.data = d; v.tag = t;
    v.exp_err = ee; v.exp = ex;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_fields(input logic wr, input logic by, input logic sg,
                              input logic [15:0] a, input logic [15:0] d,
                              input logic [TAG_W-1:0] t);
    req_write = wr; req_byte = by; req_signed = sg;
    req_address = a; req_store_data = d; req_tag = t;
  endtask

  // Present a request and return right after the accepting edge.
  task automatic accept_req(input vec_t v);
    int n;
    @(negedge clk);
    drive_fields(v.wr, v.by, v.sg, v.addr, v.data, v.tag);
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("ready_timeout", 0, 1);
    if (!v.wr && v.exp_err == 2'b00) exp_q.push_back({v.tag, v.exp});
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [15:0] al;
    al = {v.addr[15:1], 1'b0};
    accept_req(v);
    @(negedge clk); // cycle 0
    if (v.exp_err != 2'b00) begin
      chk("err_valid", err_valid, 1);
      chk("err_code", err_code, v.exp_err);
      chk("err_no_strobe", {MemRead, MemWrite}, 0);
      @(negedge clk);
      chk("err_ready_c1", req_ready, 1);
      chk("err_pulse_end", err_valid, 0);
    end else if (!v.wr) begin
      chk("ld_c0_strobes", {MemRead, MemWrite}, 2'b10);
      chk("ld_c0_addr", address, al);
      @(negedge clk);
      chk("ld_c1_idle", {MemRead, MemWrite, req_ready, wb_valid}, 0);
      @(negedge clk);
      chk("ld_c2_wb_ready", {wb_valid, req_ready}, 2'b11);
    end else if (!v.by) begin
      chk("st_c0_strobes", {MemRead, MemWrite}, 2'b01);
      chk("st_c0_addr", address, v.addr);
      chk("st_c0_wdata", write_data, v.exp);
      @(negedge clk);
      chk("st_c1_ready", req_ready, 1);
    end else begin
      chk("rmw_c0_strobes", {MemRead, MemWrite}, 2'b10);
      chk("rmw_c0_addr", address, al);
      @(negedge clk);
      chk("rmw_c1_strobes", {MemRead, MemWrite, req_ready}, 3'b010);
      chk("rmw_c1_addr", address, al);
      chk("rmw_c1_wdata", write_data, v.exp);
      @(negedge clk);
      chk("rmw_c2_ready", {req_ready, MemWrite}, 2'b10);
    end
  endtask

  task automatic check_reset_values(input string tagname);
    chk({tagname, "_ready"}, req_ready, 1);
    chk({tagname, "_strobes"}, {MemRead, MemWrite}, 0);
    chk({tagname, "_bus"}, {address, write_data}, 0);
    chk({tagname, "_wb"}, {wb_valid, wb_tag, wb_data}, 0);
    chk({tagname, "_err"}, {err_valid, err_code}, 0);
    chk({tagname, "_state"}, dbg_state, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int r0, w0, a0, n;
    checks = 0; failures = 0; rd_strobes = 0; wr_strobes = 0; accepts = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom_range(0, 255));
    read_data_mem = 16'h0;
    req_valid = 1'b0;
    drive_fields(0, 0, 0, 16'h0, 16'h0, '0);
    rst_n = 1'b0;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    //              wr by sg addr     data     tag ee     exp
    vecs[0]  = mk(1, 0, 0, 16'h0010, 16'hBEEF, 0, 2'b00, 16'hBEEF);
    vecs[1]  = mk(0, 0, 0, 16'h0010, 16'h0000, 5, 2'b00, 16'hBEEF);
    vecs[2]  = mk(1, 0, 0, 16'h0020, 16'h80F7, 0, 2'b00, 16'h80F7);
    vecs[3]  = mk(0, 1, 1, 16'h0020, 16'h0000, 1, 2'b00, 16'hFF80);
    vecs[4]  = mk(0, 1, 0, 16'h0021, 16'h0000, 2, 2'b00, 16'h00F7);
    vecs[5]  = mk(0, 1, 1, 16'h0021, 16'h0000, 3, 2'b00, 16'hFFF7);
    vecs[6]  = mk(1, 0, 0, 16'h0030, 16'h1234, 0, 2'b00, 16'h1234);
    vecs[7]  = mk(1, 1, 0, 16'h0031, 16'h55AB, 0, 2'b00, 16'h12AB);
    vecs[8]  = mk(0, 0, 0, 16'h0030, 16'h0000, 4, 2'b00, 16'h12AB);
    vecs[9]  = mk(1, 1, 0, 16'h0030, 16'h77CD, 0, 2'b00, 16'hCDAB);
    vecs[10] = mk(0, 0, 0, 16'h0030, 16'h0000, 6, 2'b00, 16'hCDAB);
    vecs[11] = mk(0, 0, 0, 16'h0005, 16'h0000, 1, 2'b01, 16'h0000);
    vecs[12] = mk(1, 0, 0, 16'h03FF, 16'h1111, 0, 2'b10, 16'h0000);
    vecs[13] = mk(0, 1, 0, 16'h0400, 16'h0000, 2, 2'b10, 16'h0000);
    vecs[14] = mk(1, 0, 0, 16'h03FE, 16'h5A3C, 0, 2'b00, 16'h5A3C);
    vecs[15] = mk(0, 1, 0, 16'h03FF, 16'h0000, 7, 2'b00, 16'h003C);

    for (int i = 0; i < 16; i++) run_vec(vecs[i]);

    chk("mem_0x10", mem[16'h10], 8'hBE);
    chk("mem_0x11", mem[16'h11], 8'hEF);
    chk("mem_0x30", {mem[16'h30], mem[16'h31]}, 16'hCDAB);
    chk("wb_hold", {wb_tag, wb_data}, {3'd7, 16'h003C});
    chk("err_code_hold", err_code, 2'b10);

    // Back-to-back: req_valid held high across three queued requests.
    r0 = rd_strobes; w0 = wr_strobes; a0 = accepts;
    @(negedge clk);
    drive_fields(1, 0, 0, 16'h0040, 16'h1111, 0);
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!req_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!req_ready) chk("b2b_ready_timeout", 0, 1);
      if (k == 2) exp_q.push_back({3'd2, 16'h1111});
      @(posedge clk);
      #1;
      if (k == 0) drive_fields(1, 0, 0, 16'h0042, 16'h2222, 0);
      else if (k == 1) drive_fields(0, 0, 0, 16'h0040, 16'h0000, 2);
      else req_valid = 1'b0;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("b2b_accepts", accepts - a0, 3);
    chk("b2b_writes", wr_strobes - w0, 2);
    chk("b2b_reads", rd_strobes - r0, 1);
    chk("b2b_mem", {mem[16'h40], mem[16'h41], mem[16'h42], mem[16'h43]}, 32'h11112222);

    // Reset while a byte store sits in READ.
    run_vec(mk(1, 0, 0, 16'h0050, 16'h6789, 0, 2'b00, 16'h6789));
    accept_req(mk(1, 1, 0, 16'h0051, 16'h00EE, 0, 2'b00, 16'h0000));
    @(negedge clk);
    chk("abort_in_read", {dbg_state, MemRead}, {3'd1, 1'b1});
    rst_n = 1'b0;
    #1;
    check_reset_values("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_mem_untouched", {mem[16'h50], mem[16'h51]}, 16'h6789);
    run_vec(mk(0, 0, 0, 16'h0050, 16'h0000, 3, 2'b00, 16'h6789));
    run_vec(mk(1, 1, 0, 16'h0051, 16'h00EE, 0, 2'b00, 16'h67EE));
    repeat (2) @(negedge clk);
    chk("after_abort_mem", {mem[16'h50], mem[16'h51]}, 16'h67EE);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
